// File: rtl/mdu_sched_if.sv
// mdu_sched_if: execute-stage request, multiply/divide unit handshake and
// HI/LO write-back signals of the mul/div sequencing controller.
// master = surrounding pipeline and units, slave = mdu_sched.
interface mdu_sched_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    logic                req_valid;
    logic                req_is_div;
    logic                req_sign;
    logic [DATA_W-1:0]   req_a;
    logic [DATA_W-1:0]   req_b;
    logic                flush;
    logic                is_busbusy;
    logic                stall_o;
    logic                mul_start;
    logic                div_start;
    logic                op_sign;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_result;
    logic                div_done;
    logic [2*DATA_W-1:0] div_result;
    logic                hilo_we;
    logic [DATA_W-1:0]   hi_wdata;
    logic [DATA_W-1:0]   lo_wdata;
    logic [CNT_W-1:0]    last_lat;

    modport master (
        output req_valid, req_is_div, req_sign, req_a, req_b,
        output flush, is_busbusy,
        output mul_done, mul_result, div_done, div_result,
        input  stall_o, mul_start, div_start, op_sign, op_a, op_b,
        input  hilo_we, hi_wdata, lo_wdata, last_lat
    );

    modport slave (
        input  req_valid, req_is_div, req_sign, req_a, req_b,
        input  flush, is_busbusy,
        input  mul_done, mul_result, div_done, div_result,
        output stall_o, mul_start, div_start, op_sign, op_a, op_b,
        output hilo_we, hi_wdata, lo_wdata, last_lat
    );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: sequencing controller for the shared multi-cycle multiply/divide
// unit behind the execute stage. Accepts one request, pulses the selected
// unit's start, waits for its done, buffers {hi,lo} and writes HI/LO when the
// bus is free. Flushed operations are drained and their result discarded.
// Optional build macro: MDU_DIV0_FAST_EN -- a divide by zero bypasses the
// divider and writes hi = dividend, lo = all-ones directly.
module mdu_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       reset,
    mdu_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_WB,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_d;

    logic                is_div_q;
    logic                sign_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    lat_q;
    logic [CNT_W-1:0]    cnt_inc;

    logic                accept;
    logic                capture;
    logic                drop;
    logic                div0_fast;
    logic                unit_done;
    logic [2*DATA_W-1:0] unit_result;

    logic                stall;
    logic                mul_start;
    logic                div_start;
    logic                hilo_we;

`ifdef MDU_DIV0_FAST_EN
    assign div0_fast = bus.req_is_div && (bus.req_b == '0);
`else
    assign div0_fast = 1'b0;
`endif

    // Only the unit that was started is listened to; the other one's done is ignored.
    assign unit_done   = is_div_q ? bus.div_done   : bus.mul_done;
    assign unit_result = is_div_q ? bus.div_result : bus.mul_result;

    // The done cycle itself counts, so last_lat is the START-to-done distance.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d   = state;
        stall     = 1'b0;
        mul_start = 1'b0;
        div_start = 1'b0;
        hilo_we   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                stall = bus.req_valid;
                if (bus.req_valid && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = div0_fast ? S_WB : S_START;
                end
            end
            S_START: begin
                stall     = 1'b1;
                mul_start = !is_div_q;
                div_start = is_div_q;
                state_d   = bus.flush ? S_DRAIN : S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = S_DRAIN;
                end else if (unit_done) begin
                    capture = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                stall = bus.is_busbusy;
                if (bus.flush) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else if (!bus.is_busbusy) begin
                    hilo_we = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                stall = bus.req_valid;
                if (unit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, latency counter and result buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
        end else begin
            if (accept) begin
                is_div_q <= bus.req_is_div;
                sign_q   <= bus.req_sign;
                a_q      <= bus.req_a;
                b_q      <= bus.req_b;
                cnt_q    <= '0;
                if (div0_fast) begin
                    hi_q  <= bus.req_a;
                    lo_q  <= '1;
                    lat_q <= '0;
                end
            end
            if (state == S_BUSY) begin
                cnt_q <= cnt_inc;
            end
            if (capture) begin
                hi_q  <= unit_result[2*DATA_W-1:DATA_W];
                lo_q  <= unit_result[DATA_W-1:0];
                lat_q <= cnt_inc;
            end
            if (drop) begin
                hi_q <= '0;
                lo_q <= '0;
            end
        end
    end

    assign bus.stall_o   = stall;
    assign bus.mul_start = mul_start;
    assign bus.div_start = div_start;
    assign bus.hilo_we   = hilo_we;
    assign bus.op_sign   = sign_q;
    assign bus.op_a      = a_q;
    assign bus.op_b      = b_q;
    assign bus.hi_wdata  = hi_q;
    assign bus.lo_wdata  = lo_q;
    assign bus.last_lat  = lat_q;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: self-checking bench for mdu_sched. Acts as execute stage,
// multiplier and divider. Inputs are driven on the falling edge and outputs
// sampled 1 ns later. Honours MDU_DIV0_FAST_EN when the bench is built with it.
module tb_mdu_sched;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mdu_sched_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mdu_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        is_div;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned lat;
        int unsigned busy_n;
        logic [63:0] exp_res;
        logic [5:0]  exp_lat;
    } vec_t;

    vec_t tbl[6];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // What an ideal multiplier/divider returns: {hi,lo} or {remainder,quotient}.
    function automatic logic [63:0] unit_result(input logic is_div, input logic sign,
                                                input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!is_div) return sign ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 32'd0) return {a, 32'h0BAD0D10};
        if (sign) return {32'(sa % sb), 32'(sa / sb)};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
        chk({tag, "_mstart"}, 64'(bus.mul_start), 64'd0);
        chk({tag, "_dstart"}, 64'(bus.div_start), 64'd0);
        chk({tag, "_we"}, 64'(bus.hilo_we), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle_outputs(tag);
        chk({tag, "_op_a"}, 64'(bus.op_a), 64'd0);
        chk({tag, "_op_b"}, 64'(bus.op_b), 64'd0);
        chk({tag, "_op_sign"}, 64'(bus.op_sign), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi_wdata), 64'd0);
        chk({tag, "_lo"}, 64'(bus.lo_wdata), 64'd0);
        chk({tag, "_lat"}, 64'(bus.last_lat), 64'd0);
    endtask

    // One complete operation, entered on a falling edge with the FSM idle.
    // Accept at cycle 0, START at 1, selected done at 1+lat, WB from lat+2,
    // busbusy held for busy_n WB cycles, write on the last cycle.
    task automatic run_op(input logic is_div, input logic sign, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned lat, input int unsigned busy_n,
                          input logic [63:0] exp_res_in, input logic [5:0] exp_lat_in,
                          input string tag);
        logic        fast;
        logic        sel_done;
        logic [63:0] exp_res;
        logic [5:0]  exp_lat;
        int unsigned w0;
        int unsigned wr;
        fast    = 1'b0;
        exp_res = exp_res_in;
        exp_lat = exp_lat_in;
`ifdef MDU_DIV0_FAST_EN
        fast = is_div && (b == 32'd0);
`endif
        if (fast) begin
            exp_res = {a, 32'hFFFF_FFFF};
            exp_lat = 6'd0;
        end
        w0 = fast ? 1 : lat + 2;
        wr = w0 + busy_n;
        for (int unsigned c = 0; c <= wr; c++) begin
            bus.req_valid  = 1'b1;
            bus.req_is_div = is_div;
            bus.req_sign   = sign;
            bus.req_a      = a;
            bus.req_b      = b;
            bus.flush      = 1'b0;
            bus.is_busbusy = (c >= w0) ? (c < wr) : 1'($urandom % 2);
            sel_done       = !fast && (c == 1 + lat);
            bus.mul_done   = is_div ? 1'($urandom % 4 == 0) : sel_done;
            bus.div_done   = is_div ? sel_done : 1'($urandom % 4 == 0);
            bus.mul_result = is_div ? {$urandom, $urandom} : unit_result(is_div, sign, a, b);
            bus.div_result = is_div ? unit_result(is_div, sign, a, b) : {$urandom, $urandom};
            #1;
            chk({tag, "_stall"}, 64'(bus.stall_o), 64'(c != wr));
            chk({tag, "_mstart"}, 64'(bus.mul_start), 64'(c == 1 && !fast && !is_div));
            chk({tag, "_dstart"}, 64'(bus.div_start), 64'(c == 1 && !fast && is_div));
            chk({tag, "_we"}, 64'(bus.hilo_we), 64'(c == wr));
            if (c == 1) begin
                chk({tag, "_op_a"}, 64'(bus.op_a), 64'(a));
                chk({tag, "_op_b"}, 64'(bus.op_b), 64'(b));
                chk({tag, "_op_sign"}, 64'(bus.op_sign), 64'(sign));
            end
            if (c == wr) begin
                chk({tag, "_hi"}, 64'(bus.hi_wdata), 64'(exp_res[63:32]));
                chk({tag, "_lo"}, 64'(bus.lo_wdata), 64'(exp_res[31:0]));
                chk({tag, "_lat"}, 64'(bus.last_lat), 64'(exp_lat));
            end
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.mul_done   = 1'b0;
        bus.div_done   = 1'b0;
        bus.is_busbusy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_div;
        logic        r_sign;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int unsigned r_lat;
        int unsigned r_busy;

        tbl[0] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,          2, 0, 64'hFFFF_FFFF_FFFF_FFF1, 6'd2};
        tbl[1] = '{1'b1, 1'b0, 32'd100,       32'd7,          5, 3, 64'h0000_0002_0000_000E, 6'd5};
        tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1, 1, 64'hFFFF_FFFE_0000_0001, 6'd1};
        tbl[3] = '{1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7,          3, 0, 64'hFFFF_FFFE_FFFF_FFF2, 6'd3};
        tbl[4] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0100, 70, 0, 64'h0000_0078_0012_3456, 6'd63};
        tbl[5] = '{1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000,  4, 2, 64'hC000_0000_8000_0000, 6'd4};

        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        bus.req_sign   = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.flush      = 1'b0;
        bus.is_busbusy = 1'b0;
        bus.mul_done   = 1'b0;
        bus.div_done   = 1'b0;
        bus.mul_result = '0;
        bus.div_result = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].is_div, tbl[i].sign, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].busy_n,
                   tbl[i].exp_res, tbl[i].exp_lat, $sformatf("tbl%0d", i));
        end

        // Flush in BUSY; a second request waits until the divider's done drains.
        bus.req_valid = 1'b1; bus.req_is_div = 1'b1; bus.req_sign = 1'b1;
        bus.req_a = 32'd1000; bus.req_b = 32'd3;
        #1; chk("drain_acc_stall", 64'(bus.stall_o), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1; chk("drain_dstart", 64'(bus.div_start), 64'd1);
        @(negedge clk);
        bus.flush = 1'b1;
        #1; chk("drain_flush_stall", 64'(bus.stall_o), 64'd1);
        chk("drain_flush_we", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0; bus.req_valid = 1'b1; bus.req_is_div = 1'b0; bus.req_sign = 1'b0;
        bus.req_a = 32'd6; bus.req_b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            bus.mul_done = (i == 1);
            bus.div_done = (i == 2);
            #1;
            chk("drain_wait_stall", 64'(bus.stall_o), 64'd1);
            chk("drain_wait_mstart", 64'(bus.mul_start), 64'd0);
            chk("drain_wait_dstart", 64'(bus.div_start), 64'd0);
            chk("drain_wait_we", 64'(bus.hilo_we), 64'd0);
            @(negedge clk);
        end
        bus.mul_done = 1'b0; bus.div_done = 1'b0;
        run_op(1'b0, 1'b0, 32'd6, 32'd7, 1, 0, 64'd42, 6'd1, "drain_second");

        // Flush and mul_done in the same BUSY cycle: flush wins, FSM drains.
        bus.req_valid = 1'b1; bus.req_is_div = 1'b0; bus.req_sign = 1'b1;
        bus.req_a = 32'd9; bus.req_b = 32'd9;
        #1; @(negedge clk);
        bus.req_valid = 1'b0;
        #1; chk("fd_mstart", 64'(bus.mul_start), 64'd1);
        @(negedge clk);
        bus.flush = 1'b1; bus.mul_done = 1'b1; bus.mul_result = 64'd81;
        #1; chk("fd_same_we", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0; bus.mul_done = 1'b0; bus.req_valid = 1'b1; bus.req_sign = 1'b0;
        bus.req_a = 32'd3; bus.req_b = 32'd4;
        #1; chk("fd_drain_stall", 64'(bus.stall_o), 64'd1);
        chk("fd_drain_we", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.mul_done = 1'b1;
        #1; chk("fd_drain_mstart", 64'(bus.mul_start), 64'd0);
        chk("fd_drain_we2", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.mul_done = 1'b0;
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 2, 1, 64'd12, 6'd2, "fd_next");

        // Flush while WB waits on a busy bus drops the result.
        bus.req_valid = 1'b1; bus.req_is_div = 1'b0; bus.req_sign = 1'b0;
        bus.req_a = 32'd5; bus.req_b = 32'd5;
        #1; @(negedge clk);
        bus.req_valid = 1'b0;
        #1; @(negedge clk);
        bus.mul_done = 1'b1; bus.mul_result = 64'd25;
        #1; @(negedge clk);
        bus.mul_done = 1'b0; bus.is_busbusy = 1'b1;
        #1; chk("wbf_busy_stall", 64'(bus.stall_o), 64'd1);
        chk("wbf_busy_we", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.is_busbusy = 1'b0; bus.flush = 1'b1;
        #1; chk("wbf_flush_we", 64'(bus.hilo_we), 64'd0);
        chk("wbf_flush_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1; check_idle_outputs("wbf_after");
        @(negedge clk);

        // Reset in the middle of BUSY, then a stray done, then a clean request.
        bus.req_valid = 1'b1; bus.req_is_div = 1'b1; bus.req_sign = 1'b0;
        bus.req_a = 32'd50; bus.req_b = 32'd5;
        #1; @(negedge clk);
        bus.req_valid = 1'b0;
        #1; @(negedge clk);
        reset = 1'b1;
        #1; @(negedge clk);
        reset = 1'b0;
        #1; check_all_zero("rst_mid");
        @(negedge clk);
        bus.div_done = 1'b1; bus.div_result = 64'hDEAD_BEEF_0000_0001;
        #1; check_idle_outputs("rst_stray");
        @(negedge clk);
        bus.div_done = 1'b0;
        run_op(1'b1, 1'b0, 32'd50, 32'd5, 2, 0, 64'h0000_0000_0000_000A, 6'd2, "rst_next");

        // Divide by zero: bypass when the fast path is built in, divider otherwise.
        run_op(1'b1, 1'b1, 32'd42, 32'd0, 3, 0, unit_result(1'b1, 1'b1, 32'd42, 32'd0), 6'd3, "div0");

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            r_div  = 1'($urandom % 2);
            r_sign = 1'($urandom % 2);
            r_a    = $urandom;
            r_b    = ($urandom % 8 == 0) ? 32'd0 : $urandom;
            r_lat  = ($urandom % 10 == 0) ? 60 + ($urandom % 10) : 1 + ($urandom % 8);
            r_busy = $urandom % 4;
            run_op(r_div, r_sign, r_a, r_b, r_lat, r_busy, unit_result(r_div, r_sign, r_a, r_b),
                   (r_lat > 63) ? 6'd63 : 6'(r_lat), $sformatf("rnd%0d", n));
            for (int unsigned k = 0; k < $urandom % 3; k++) begin
                bus.mul_done = 1'($urandom % 2);
                bus.div_done = 1'($urandom % 2);
                #1; check_idle_outputs("rnd_idle");
                @(negedge clk);
            end
            bus.mul_done = 1'b0;
            bus.div_done = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
